// File: rtl/alu_pkg.sv
// Shared ALU types: flag layout, sel encodings, and the queued result entry.
package alu_pkg;

   typedef struct packed {
      logic cout;
      logic negative;
      logic zero;
      logic overflow;
   } alu_flags_t;

   localparam int FLAG_COUT = 3;
   localparam int FLAG_NEG  = 2;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_OVF  = 0;

   typedef enum logic [3:0] {
      SEL_AND  = 4'b0000,
      SEL_OR   = 4'b0001,
      SEL_NOT  = 4'b0010,
      SEL_NOR  = 4'b0011,
      SEL_XOR  = 4'b0100,
      SEL_NAND = 4'b0101
   } alu_sel_e;

   typedef struct packed {
      logic [31:0] y;
      logic [3:0]  sel;
      alu_flags_t  flags;
   } alu_entry_t;

   localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer bundle for alu_result_queue; slave is the queue side.
interface alu_result_queue_if #(parameter int DEPTH = 4);
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              in_y;
   logic [3:0]               in_sel;
   logic [3:0]               in_flags;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_y;
   logic [3:0]               out_sel;
   logic [3:0]               out_flags;
   logic [$clog2(DEPTH):0]   count;
   logic                     flag_clr;
   logic [3:0]               sticky_flags;

   modport slave (
      input  in_valid, in_y, in_sel, in_flags, out_ready, flag_clr,
      output in_ready, out_valid, out_y, out_sel, out_flags, count, sticky_flags
   );

   modport master (
      output in_valid, in_y, in_sel, in_flags, out_ready, flag_clr,
      input  in_ready, out_valid, out_y, out_sel, out_flags, count, sticky_flags
   );
endinterface

// File: rtl/alu_result_queue_ram.sv
// Entry storage: synchronous write, combinational read; contents are never reset.
module alu_result_ram #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_queue.sv
// Registered FIFO of ALU results with valid/ready on both sides.
// Sticky flag summary is built only when ALU_RESULT_QUEUE_STICKY_EN is defined.
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   alu_result_queue_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   alu_entry_t    w_wr_entry;
   alu_entry_t    w_rd_entry;

   // in_ready depends on registered count only, so a full queue refuses even during a pop
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_push   = bus.in_valid && !w_full;
   assign w_pop    = bus.out_ready && !w_empty;

   assign bus.in_ready  = !w_full;
   assign bus.out_valid = !w_empty;
   assign bus.count     = r_count;

   assign w_wr_entry = {bus.in_y, bus.in_sel, bus.in_flags};

   alu_result_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_entry)
   );

   assign bus.out_y     = w_empty ? '0 : w_rd_entry.y;
   assign bus.out_sel   = w_empty ? '0 : w_rd_entry.sel;
   assign bus.out_flags = w_empty ? '0 : w_rd_entry.flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ALU_RESULT_QUEUE_STICKY_EN
   logic [3:0] r_sticky;

   // clear and push in one cycle leave just the pushed flags
   always_ff @(posedge clk) begin
      if (rst) r_sticky <= '0;
      else     r_sticky <= (bus.flag_clr ? 4'b0 : r_sticky) | (w_push ? bus.in_flags : 4'b0);
   end

   assign bus.sticky_flags = r_sticky;
`else
   logic w_unused_clr;
   assign w_unused_clr     = bus.flag_clr;
   assign bus.sticky_flags = 4'b0;
`endif

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered result buffer directly downstream of the 32-bit ALU. Each cycle it can capture one ALU result: Y, the four status flags, and the select code that produced them. Captured entries are held in a small FIFO and handed to the consumer over a valid/ready handshake. Optionally, it keeps a sticky summary of every flag accepted since the last clear.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, minimum 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  ALU result on in_* is presented
- in_ready  output  1  queue can accept an entry this cycle
- in_y  input  32  ALU result Y
- in_sel  input  4  ALU sel code that produced in_y
- in_flags  input  4  {Cout, Negative, Zero, Overflow}
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head entry
- out_y  output  32  head entry Y
- out_sel  output  4  head entry sel
- out_flags  output  4  head entry flags, same bit order as in_flags
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- flag_clr  input  1  clear sticky flags
- sticky_flags  output  4  OR of all accepted in_flags since reset or the last clear

## Operation
- Push occurs when in_valid && in_ready. The entry {in_y, in_sel, in_flags} is written at wr_ptr, and wr_ptr advances.
- Pop occurs when out_valid && out_ready. rd_ptr advances.
- in_ready = (count != DEPTH). It is derived from registered count only; there is no combinational path from out_ready. A full queue therefore refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- When out_valid=0, out_y, out_sel and out_flags are forced to 0.
- Occupancy update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- When in_valid && !in_ready, the input is ignored (not dropped silently into storage). The producer must hold its data.
- When out_ready is asserted while empty, nothing happens; pointers are unchanged.
- Data is stored bit-exact. No flag recomputation, and X values pass through unchanged.
- Sticky flags: sticky_next = (flag_clr ? 4'b0 : sticky_flags) | (push ? in_flags : 4'b0).
  - A clear and a push in the same cycle leave exactly the pushed flags set.

## Timing
- Write-to-read latency is 1 cycle. An entry pushed at edge N is visible on out_* after edge N, when the queue was empty. There is no fall-through.
- A sustained push+pop stream runs at 1 entry/cycle once count is between 1 and DEPTH-1.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0
  - in_ready=1, out_valid=0
  - out_y=0, out_sel=0, out_flags=0
  - sticky_flags=0
- Storage contents are not reset.
- Reset asserted mid-stream discards all entries on that edge. Pushes and pops in the reset cycle have no effect.
- sticky_flags updates on the same edge as the push.

## Configuration
- ALU_RESULT_QUEUE_STICKY_EN defined: the sticky flag register and flag_clr logic are built as described above.
- Undefined: sticky_flags is tied to 4'b0 and flag_clr is ignored. The ports remain present, and FIFO behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - typedef alu_flags_t (4-bit packed: cout, negative, zero, overflow)
  - FLAG_* bit index constants
  - ALU sel encodings: AND 4'b0000, OR 4'b0001, NOT 4'b0010, NOR 4'b0011, XOR 4'b0100, NAND 4'b0101
- One sub-module, alu_result_ram: DEPTH x 40-bit storage with a synchronous write port and a combinational read at rd_ptr. Control, pointers and sticky logic stay in alu_result_queue.

## Test plan
- After reset: count=0, in_ready=1, out_valid=0, out_y=0, sticky_flags=0.
- Push Y=32'h0000_0001, sel=4'b0000, flags=4'b0000, with out_ready=0 -> next cycle out_valid=1, out_y=1, out_sel=0, count=1.
- Push 4 entries (Y=10,11,12,13) with out_ready=0 -> count=4 and in_ready=0.
  - A fifth push (Y=14) is refused.
  - Draining yields 10,11,12,13 in order, then out_valid=0.
- Continuous push+pop for 20 cycles with Y incrementing from 0 -> count stays 1 and outputs are in order across pointer wrap-around.
- Sticky flags (with ALU_RESULT_QUEUE_STICKY_EN):
  - Push flags 4'b0010, then 4'b1000 -> sticky=4'b1010.
  - flag_clr together with a push of flags 4'b0001 -> sticky=4'b0001.
- Reset asserted with count=3 -> next cycle count=0 and out_valid=0; a push in the reset cycle is not stored.
